dispatch_unit_p: RTL
====================

// Module: dispatch_unit_p
// PURPOSE
//  Parametrised in-order dispatch stage between the ifetch FIFO and the issue queues.
//  Pops one instruction per cycle, decodes it to an internal opcode and allocates a ROB tag.
//  Routes each instruction to one of NUM_INT_Q integer queues (round-robin, full queues skipped), the ld/st queue or the mul queue.
//  Resolves J in the dispatch stage. Tracks ROB occupancy and honours flush from retire.
// PARAMETERS
//  DATA_W      32  instruction / PC width
//  ROB_DEPTH   32  ROB entries; power of 2, >=2; TAG_W = $clog2(ROB_DEPTH) (localparam)
//  NUM_INT_Q   2   integer issue queues, 1..8
// PORTS
//  clock                   in   1          single clock, rising edge
//  reset                   in   1          asynchronous, active-low
//  ifetch_pc_4             in   DATA_W     PC+4 of the head instruction
//  ifetch_intruction       in   DATA_W     head instruction
//  ifetch_empty            in   1          fetch FIFO empty
//  Dispatch_ren            out  1          combinational pop of fetch FIFO
//  Dispatch_jmp            out  1          registered 1-cycle redirect pulse
//  Dispatch_jmp_addr       out  DATA_W     redirect target
//  issueque_integer_full   in   NUM_INT_Q  per-queue full
//  issueque_full_ld_st     in   1          ld/st queue full
//  issueque_mul_full       in   1          mul queue full
//  dispatch_en_integer     out  NUM_INT_Q  one-hot write enable
//  dispatch_en_ld_st       out  1          ld/st write enable
//  dispatch_en_mul         out  1          mul write enable
//  dispatch_opcode         out  4          internal opcode (package)
//  dispatch_rs_reg         out  5          source register rs
//  dispatch_rt_reg         out  5          source register rt
//  dispatch_rd_reg         out  5          destination (rd for R-type, rt for lw/addi)
//  dispatch_shfamt         out  5          shift amount
//  dispatch_imm            out  16         immediate
//  dispatch_rd_tag         out  TAG_W      allocated ROB tag
//  dispatch_illegal        out  1          1-cycle pulse: undecodable instruction dropped
//  retire_valid            in   1          one ROB entry retires this cycle
//  flush                   in   1          squash: ROB empty, dispatch cancelled
// BEHAVIOUR
//  Reset: every output 0; rr_ptr=0, tag_head=0, rob_count=0.
//  Decode (comb): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL -> integer;
//    funct 0x18 MUL -> mul; opcode 0x08 ADDI -> integer; 0x23 LW, 0x2B SW -> ld/st; 0x02 J -> jump; else illegal.
//  target_ok: integer = any issueque_integer_full bit clear; ld/st = !issueque_full_ld_st;
//    mul = !issueque_mul_full; J and illegal always ok.
//  rob_full = (rob_count == ROB_DEPTH); J and illegal need no ROB entry.
//  Dispatch_ren = !ifetch_empty & !flush & target_ok & (!rob_full | J | illegal).
//  Latency: outputs are registered 1 cycle after Dispatch_ren; every en_* is a single-cycle pulse.
//  Integer select: first non-full queue searched from rr_ptr upward (mod NUM_INT_Q).
//    On dispatch rr_ptr <= sel+1 (wrap to 0).
//  Tag: dispatch_rd_tag = tag_head; tag_head increments mod ROB_DEPTH on each ROB-allocating pop.
//  rob_count: +1 on allocate, -1 on retire_valid, unchanged on both; retire_valid at count 0 is ignored.
//  J: Dispatch_jmp=1 next cycle, addr = {pc_4[31:28], instr[25:0], 2'b00}; no en_* or tag.
//    The instruction after J is not popped in the cycle Dispatch_jmp is high (1 bubble).
//  flush (highest priority): Dispatch_ren=0 that cycle; next cycle all en_*/jmp/illegal are 0;
//    tag_head=0, rob_count=0. rr_ptr is kept.
//  Data fields (opcode/regs/imm/tag) hold their last value when no en_* is asserted.
// STRUCTURE
//  Package dispatch_pkg: internal opcode localparams (ADD=0..SW), MIPS opcode/funct constants,
//    decode class enum.
//  Sub-module rr_select #(N): round-robin first-free picker (full vector, ptr -> one-hot, any).
//  Top level: decode, ROB counter, output register.
// TESTING
//  1 add $31,$4,$0 (0x0080F820), queues empty -> ren=1; next cycle en_integer=2'b01, rd=31, rs=4, rt=0, tag=0.
//  2 mul $2,$5,$31 (0x00BF1018) -> en_mul=1, rd=2, tag=1; with mul_full=1 -> ren=0, no en, tag not consumed.
//  3 four adds back-to-back, NUM_INT_Q=2 -> en_integer 01,10,01,10; with full=2'b01 -> all go to 10.
//  4 J 0x08000010 at pc_4=0x00000004 -> Dispatch_jmp=1, addr=0x00000040; next cycle ren=0; no tag used.
//  5 ROB_DEPTH=4: 5 adds, no retire -> 4 dispatched (tags 0-3), ren=0;
//    retire_valid pulse -> 5th dispatched with tag 0.
//  6 flush in the same cycle as a valid add -> ren=0, no en next cycle; next add gets tag=0.
//    Async reset mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/dispatch_unit_p_pkg.sv
// Package for the dispatch stage.
// Holds the internal opcode encoding, the MIPS opcode/funct constants, the decode class enum
// and the combinational decoder shared by the top level.
package dispatch_unit_p_pkg;

   // Internal opcodes driven on dispatch_opcode
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LW   = 4'd9;
   localparam logic [3:0] OP_SW   = 4'd10;

   // MIPS primary opcodes
   localparam logic [5:0] MIPS_RTYPE = 6'h00;
   localparam logic [5:0] MIPS_J     = 6'h02;
   localparam logic [5:0] MIPS_ADDI  = 6'h08;
   localparam logic [5:0] MIPS_LW    = 6'h23;
   localparam logic [5:0] MIPS_SW    = 6'h2B;

   // MIPS R-type funct codes
   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_SRL = 6'h02;
   localparam logic [5:0] FUNCT_MUL = 6'h18;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [2:0] {ClsInt, ClsLdSt, ClsMul, ClsJmp, ClsIll} dec_class_e;

   typedef struct packed {
      dec_class_e cls;
      logic [3:0] op;
   } decode_t;

   function automatic decode_t decode(input logic [31:0] instr);
      decode_t d;
      d.cls = ClsIll;
      d.op  = OP_ADD;
      unique case (instr[31:26])
         MIPS_RTYPE: begin
            unique case (instr[5:0])
               FUNCT_ADD: begin d.cls = ClsInt; d.op = OP_ADD; end
               FUNCT_SUB: begin d.cls = ClsInt; d.op = OP_SUB; end
               FUNCT_AND: begin d.cls = ClsInt; d.op = OP_AND; end
               FUNCT_OR:  begin d.cls = ClsInt; d.op = OP_OR;  end
               FUNCT_SLT: begin d.cls = ClsInt; d.op = OP_SLT; end
               FUNCT_SLL: begin d.cls = ClsInt; d.op = OP_SLL; end
               FUNCT_SRL: begin d.cls = ClsInt; d.op = OP_SRL; end
               FUNCT_MUL: begin d.cls = ClsMul; d.op = OP_MUL; end
               default:   d.cls = ClsIll;
            endcase
         end
         MIPS_ADDI: begin d.cls = ClsInt;  d.op = OP_ADDI; end
         MIPS_LW:   begin d.cls = ClsLdSt; d.op = OP_LW;   end
         MIPS_SW:   begin d.cls = ClsLdSt; d.op = OP_SW;   end
         MIPS_J:    d.cls = ClsJmp;
         default:   d.cls = ClsIll;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dispatch_unit_p_if.sv
// Dispatch bus interface: fetch-FIFO head, issue-queue write side, retire/flush controls.
// master: the dispatch unit.  slave: the surrounding pipeline (fetch, issue queues, ROB).
interface dispatch_unit_p_if #(
   parameter int DATA_W    = 32,
   parameter int NUM_INT_Q = 2,
   parameter int TAG_W     = 5
);
   logic [DATA_W-1:0]    ifetch_pc_4;
   logic [DATA_W-1:0]    ifetch_intruction;
   logic                 ifetch_empty;
   logic                 Dispatch_ren;
   logic                 Dispatch_jmp;
   logic [DATA_W-1:0]    Dispatch_jmp_addr;
   logic [NUM_INT_Q-1:0] issueque_integer_full;
   logic                 issueque_full_ld_st;
   logic                 issueque_mul_full;
   logic [NUM_INT_Q-1:0] dispatch_en_integer;
   logic                 dispatch_en_ld_st;
   logic                 dispatch_en_mul;
   logic [3:0]           dispatch_opcode;
   logic [4:0]           dispatch_rs_reg;
   logic [4:0]           dispatch_rt_reg;
   logic [4:0]           dispatch_rd_reg;
   logic [4:0]           dispatch_shfamt;
   logic [15:0]          dispatch_imm;
   logic [TAG_W-1:0]     dispatch_rd_tag;
   logic                 dispatch_illegal;
   logic                 retire_valid;
   logic                 flush;

   modport master (
      input  ifetch_pc_4, ifetch_intruction, ifetch_empty,
      input  issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
      input  retire_valid, flush,
      output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
      output dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul,
      output dispatch_opcode, dispatch_rs_reg, dispatch_rt_reg, dispatch_rd_reg,
      output dispatch_shfamt, dispatch_imm, dispatch_rd_tag, dispatch_illegal
   );

   modport slave (
      output ifetch_pc_4, ifetch_intruction, ifetch_empty,
      output issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
      output retire_valid, flush,
      input  Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
      input  dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul,
      input  dispatch_opcode, dispatch_rs_reg, dispatch_rt_reg, dispatch_rd_reg,
      input  dispatch_shfamt, dispatch_imm, dispatch_rd_tag, dispatch_illegal
   );
endinterface

// File: rtl/dispatch_unit_p_rr_select.sv
// Round-robin first-free picker.
// Ports: full (per-queue full), ptr (search start) -> sel (one-hot), sel_idx (binary), any.
module dispatch_unit_p_rr_select #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  full,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  sel,
   output logic [PW-1:0] sel_idx,
   output logic          any
);
   int unsigned idx;

   always_comb begin
      sel     = '0;
      sel_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any && !full[idx]) begin
            any          = 1'b1;
            sel[idx]     = 1'b1;
            sel_idx      = PW'(idx);
         end
      end
   end
endmodule

// File: rtl/dispatch_unit_p.sv
// In-order dispatch stage: pops the fetch FIFO head, decodes it, allocates a ROB tag and writes
// one integer (round-robin), ld/st or mul issue queue. J is resolved here as a redirect pulse.
// Ports: clock, reset (async active-low), bus (dispatch_unit_p_if master modport).
module dispatch_unit_p
   import dispatch_unit_p_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ROB_DEPTH = 32,
   parameter int NUM_INT_Q = 2
) (
   input logic               clock,
   input logic               reset,
   dispatch_unit_p_if.master bus
);
   localparam int TAG_W = $clog2(ROB_DEPTH);
   localparam int CNT_W = $clog2(ROB_DEPTH + 1);
   localparam int PW    = (NUM_INT_Q > 1) ? $clog2(NUM_INT_Q) : 1;

   decode_t              dec;
   logic                 needs_rob, target_ok, rob_full, ren, retire_eff;
   logic [NUM_INT_Q-1:0] int_sel;
   logic [PW-1:0]        int_idx, rr_ptr, rr_next;
   logic                 int_any;
   logic [CNT_W-1:0]     rob_count, cnt_next;
   logic [TAG_W-1:0]     tag_head;
   logic [31:0]          instr;

   logic                 jmp_q, ill_q, en_ls_q, en_mul_q;
   logic [NUM_INT_Q-1:0] en_int_q;
   logic [DATA_W-1:0]    jaddr_q;
   logic [3:0]           op_q;
   logic [4:0]           rs_q, rt_q, rd_q, sh_q;
   logic [15:0]          imm_q;
   logic [TAG_W-1:0]     tag_q;

   assign instr = bus.ifetch_intruction[31:0];

   dispatch_unit_p_rr_select #(.N(NUM_INT_Q)) u_rr_select (
      .full    (bus.issueque_integer_full),
      .ptr     (rr_ptr),
      .sel     (int_sel),
      .sel_idx (int_idx),
      .any     (int_any)
   );

   always_comb begin
      dec       = decode(instr);
      needs_rob = (dec.cls == ClsInt) || (dec.cls == ClsLdSt) || (dec.cls == ClsMul);
      unique case (dec.cls)
         ClsInt:  target_ok = int_any;
         ClsLdSt: target_ok = !bus.issueque_full_ld_st;
         ClsMul:  target_ok = !bus.issueque_mul_full;
         default: target_ok = 1'b1;
      endcase
      rob_full = (rob_count == CNT_W'(ROB_DEPTH));
      // jmp_q blocks the pop: the instruction behind a J is on the wrong path
      ren = !bus.ifetch_empty && !bus.flush && !jmp_q && target_ok && (!rob_full || !needs_rob);
      rr_next    = (int_idx == PW'(NUM_INT_Q - 1)) ? '0 : int_idx + PW'(1);
      retire_eff = bus.retire_valid && (rob_count != '0);
      cnt_next   = rob_count;
      if ((ren && needs_rob) && !retire_eff) cnt_next = rob_count + CNT_W'(1);
      else if (!(ren && needs_rob) && retire_eff) cnt_next = rob_count - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         tag_head  <= '0;
         rob_count <= '0;
         jmp_q     <= 1'b0;
         ill_q     <= 1'b0;
         en_ls_q   <= 1'b0;
         en_mul_q  <= 1'b0;
         en_int_q  <= '0;
         jaddr_q   <= '0;
         op_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         sh_q      <= '0;
         imm_q     <= '0;
         tag_q     <= '0;
      end else begin
         en_int_q <= '0;
         en_ls_q  <= 1'b0;
         en_mul_q <= 1'b0;
         jmp_q    <= 1'b0;
         ill_q    <= 1'b0;
         if (bus.flush) begin
            tag_head  <= '0;
            rob_count <= '0;
         end else begin
            rob_count <= cnt_next;
            if (ren) begin
               unique case (dec.cls)
                  ClsInt: begin
                     en_int_q <= int_sel;
                     rr_ptr   <= rr_next;
                  end
                  ClsLdSt: en_ls_q  <= 1'b1;
                  ClsMul:  en_mul_q <= 1'b1;
                  ClsJmp: begin
                     jmp_q   <= 1'b1;
                     jaddr_q <= DATA_W'({bus.ifetch_pc_4[DATA_W-1 -: 4], instr[25:0], 2'b00});
                  end
                  default: ill_q <= 1'b1;
               endcase
               if (needs_rob) begin
                  op_q     <= dec.op;
                  rs_q     <= instr[25:21];
                  rt_q     <= instr[20:16];
                  // R-type writes rd, I-type writes rt
                  rd_q     <= (instr[31:26] == MIPS_RTYPE) ? instr[15:11] : instr[20:16];
                  sh_q     <= instr[10:6];
                  imm_q    <= instr[15:0];
                  tag_q    <= tag_head;
                  tag_head <= tag_head + TAG_W'(1);
               end
            end
         end
      end
   end

   assign bus.Dispatch_ren        = ren;
   assign bus.Dispatch_jmp        = jmp_q;
   assign bus.Dispatch_jmp_addr   = jaddr_q;
   assign bus.dispatch_en_integer = en_int_q;
   assign bus.dispatch_en_ld_st   = en_ls_q;
   assign bus.dispatch_en_mul     = en_mul_q;
   assign bus.dispatch_opcode     = op_q;
   assign bus.dispatch_rs_reg     = rs_q;
   assign bus.dispatch_rt_reg     = rt_q;
   assign bus.dispatch_rd_reg     = rd_q;
   assign bus.dispatch_shfamt     = sh_q;
   assign bus.dispatch_imm        = imm_q;
   assign bus.dispatch_rd_tag     = tag_q;
   assign bus.dispatch_illegal    = ill_q;
endmodule
